// File: rtl/uart_frame_pkg.sv
// Shared state codes, default header and frame-length helpers for uart_frame_tx.
// Frame length includes the checksum byte when UART_FRAME_CSUM_EN is defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ABORT  = 3'd4
    } state_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

`ifdef UART_FRAME_CSUM_EN
    localparam int unsigned CSUM_BYTES = 1;
`else
    localparam int unsigned CSUM_BYTES = 0;
`endif

    // Header + payload bytes (+ checksum byte when enabled).
    function automatic int unsigned frame_bytes(input int unsigned data_w);
        return 1 + data_w / 8 + CSUM_BYTES;
    endfunction

    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Frame sender: HEADER, payload bytes LSB first, optional XOR checksum byte, over the UART byte handshake.
// Build option: define UART_FRAME_CSUM_EN to append the checksum byte.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              send_done,
    output logic              err,
    output logic              uart_send,
    output logic [7:0]        uart_send_data,
    input  logic              uart_send_done,
    output logic [3:0]        sta
);

    localparam int unsigned NB    = frame_bytes(DATA_W);
    localparam int unsigned SR_W  = NB * 8;
    localparam int unsigned IDX_W = idx_width(NB);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              send_done_q, send_done_d;
    logic              err_q, err_d;
    logic              uart_send_q, uart_send_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [SR_W-1:0]   frame_load;

    // The whole frame is loaded at accept so every byte is simply sr_q[7:0].
`ifdef UART_FRAME_CSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = HEADER;
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            csum = csum ^ data[i*8 +: 8];
        end
    end
    assign frame_load = {csum, data, HEADER};
`else
    assign frame_load = {data, HEADER};
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        send_done_d = 1'b0;
        err_d       = 1'b0;
        uart_send_d = 1'b0;
        tx_byte_d   = tx_byte_q;

        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    sr_d    = frame_load;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_byte_d   = sr_q[7:0];
                uart_send_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Pulses are registered so they line up with the FINISH/ABORT cycle.
                if (uart_send_done) begin
                    if (idx_q == IDX_LAST) begin
                        send_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        sr_d    = sr_q >> 8;
                        state_d = ST_ISSUE;
                    end
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH, ST_ABORT: begin
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            send_done_q <= 1'b0;
            err_q       <= 1'b0;
            uart_send_q <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            send_done_q <= send_done_d;
            err_q       <= err_d;
            uart_send_q <= uart_send_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign busy           = busy_q;
    assign send_done      = send_done_q;
    assign err            = err_q;
    assign uart_send      = uart_send_q;
    assign uart_send_data = tx_byte_q;
    assign sta            = {1'b0, state_q};

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: table vectors, random frames against a byte-list model, timeout/reset/back-to-back sequences.
module tb_uart_frame_tx;

    localparam int unsigned TO_A = 20;
`ifdef UART_FRAME_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NB_A   = 5 + CS;
    localparam int NB_B   = 2 + CS;
    // Send at cycle 0, first pulse at 2, one byte every 12 cycles, send_done 11 cycles after the last pulse.
    localparam int DONE_A = 2 + 12 * (NB_A - 1) + 11;
    localparam int DONE_B = 2 + 12 * (NB_B - 1) + 11;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] data;
        int          inj_at;
        logic [31:0] inj_d;
        logic [7:0]  csum;
        int          done_cyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        a_send = 1'b0, b_send = 1'b0;
    logic [31:0] a_data = '0;
    logic [7:0]  b_data = '0;
    logic        a_busy, a_sdn, a_err, a_us, a_usdone;
    logic        b_busy, b_sdn, b_err, b_us, b_usdone;
    logic [7:0]  a_usd, b_usd;
    logic [3:0]  a_sta, b_sta;

    uart_frame_tx #(.DATA_W(32), .HEADER(8'hA5), .TIMEOUT_CYC(TO_A)) dut_a (
        .clk(clk), .rst(rst), .send(a_send), .data(a_data), .busy(a_busy),
        .send_done(a_sdn), .err(a_err), .uart_send(a_us), .uart_send_data(a_usd),
        .uart_send_done(a_usdone), .sta(a_sta)
    );

    uart_frame_tx #(.DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .send(b_send), .data(b_data), .busy(b_busy),
        .send_done(b_sdn), .err(b_err), .uart_send(b_us), .uart_send_data(b_usd),
        .uart_send_done(b_usdone), .sta(b_sta)
    );

    // UART stand-in: done pulse 10 cycles after each uart_send, except the pulse numbered drop_at.
    int   pulse_total[2] = '{0, 0};
    int   drop_at[2]     = '{-1, -1};
    int   dl[2]          = '{0, 0};
    bit   pend[2]        = '{1'b0, 1'b0};
    logic [1:0] us_w;
    logic [1:0] ud_w = '0;
    assign us_w     = {b_us, a_us};
    assign a_usdone = ud_w[0];
    assign b_usdone = ud_w[1];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ud_w[i] <= 1'b0;
            if (us_w[i]) begin
                pend[i]        <= (pulse_total[i] != drop_at[i]);
                dl[i]          <= 9;
                pulse_total[i] <= pulse_total[i] + 1;
            end else if (pend[i]) begin
                if (dl[i] == 1) begin
                    ud_w[i] <= 1'b1;
                    pend[i] <= 1'b0;
                end
                dl[i] <= dl[i] - 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] got_b[$];
    int got_c[$];
    int done_c[$];
    int err_c[$];
    logic       busy1, busy_end;
    logic [3:0] sta1, sta_done, sta_err, sta_end;
    int         stab_bad;
    logic       snap_busy, snap_us, snap_sdn, snap_err;
    logic [7:0] snap_usd;
    logic [3:0] snap_sta;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic bq_t model_frame(input logic [31:0] d, input int npay);
        bq_t q;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'hA5;
        q.push_back(8'hA5);
        for (int k = 0; k < npay; k++) begin
            b = 8'((d >> (8 * k)) & 32'hFF);
            q.push_back(b);
            x = x ^ b;
        end
`ifdef UART_FRAME_CSUM_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    task automatic cmp_bytes(input string nm, input bq_t exp);
        check({nm, " count"}, got_b.size(), exp.size());
        foreach (exp[i])
            check($sformatf("%s byte%0d", nm, i),
                  (i < got_b.size()) ? 32'(got_b[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    task automatic drive(input bit sel, input logic s, input logic [31:0] d);
        if (sel) begin
            b_send = s;
            if (s) b_data = d[7:0];
        end else begin
            a_send = s;
            if (s) a_data = d;
        end
    endtask

    // Sends d at cycle 0, optionally a second send at inj_at and a 1-cycle reset at rst_at; records ncyc cycles.
    task automatic run(input bit sel, input logic [31:0] d, input int inj_at, input logic [31:0] inj_d,
                       input int rst_at, input int ncyc);
        logic s_us, s_dn, s_er, s_bz;
        logic [7:0] s_usd;
        logic [3:0] s_st;
        got_b.delete(); got_c.delete(); done_c.delete(); err_c.delete();
        stab_bad = 0; sta_done = 4'hF; sta_err = 4'hF;
        @(negedge clk);
        drive(sel, 1'b1, d);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            s_us  = sel ? b_us   : a_us;
            s_dn  = sel ? b_sdn  : a_sdn;
            s_er  = sel ? b_err  : a_err;
            s_bz  = sel ? b_busy : a_busy;
            s_usd = sel ? b_usd  : a_usd;
            s_st  = sel ? b_sta  : a_sta;
            if (s_us) begin
                got_b.push_back(s_usd);
                got_c.push_back(c);
            end else if (s_bz && s_st == 4'd2 && got_b.size() > 0 && s_usd !== got_b[$]) begin
                stab_bad++;
            end
            if (s_dn) begin done_c.push_back(c); sta_done = s_st; end
            if (s_er) begin err_c.push_back(c);  sta_err  = s_st; end
            if (c == 1) begin busy1 = s_bz; sta1 = s_st; end
            if (c == rst_at + 1) begin
                snap_busy = s_bz; snap_us = s_us; snap_sdn = s_dn;
                snap_err  = s_er; snap_usd = s_usd; snap_sta = s_st;
            end
            busy_end = s_bz;
            sta_end  = s_st;
            rst = (c == rst_at);
            drive(sel, c == inj_at, inj_d);
        end
    endtask

    initial begin
        vec_t vt[4];
        bq_t  e, e2;
        logic [31:0] rd, ri;
        vt[0] = '{32'h12345678, -1, 32'h0,        8'hAD, DONE_A};
        vt[1] = '{32'h12345678,  3, 32'hFFFFFFFF, 8'hAD, DONE_A};
        vt[2] = '{32'hDEADBEEF, -1, 32'h0,        8'h87, DONE_A};
        vt[3] = '{32'h00000000, 30, 32'h5A5A5A5A, 8'hA5, DONE_A};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", a_busy, 0);
        check("rst send_done", a_sdn, 0);
        check("rst err", a_err, 0);
        check("rst uart_send", a_us, 0);
        check("rst uart_send_data", a_usd, 8'h00);
        check("rst sta", a_sta, 0);
        check("rst b busy", b_busy, 0);
        check("rst b sta", b_sta, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run(1'b0, vt[i].data, vt[i].inj_at, vt[i].inj_d, -1, DONE_A + 20);
            cmp_bytes($sformatf("vec%0d", i), model_frame(vt[i].data, 4));
`ifdef UART_FRAME_CSUM_EN
            check($sformatf("vec%0d csum", i), (got_b.size() > 0) ? 32'(got_b[$]) : 32'hFFFF_FFFF, vt[i].csum);
`endif
            check($sformatf("vec%0d latency", i), at(got_c, 0), 2);
            check($sformatf("vec%0d done count", i), done_c.size(), 1);
            check($sformatf("vec%0d done cycle", i), at(done_c, 0), vt[i].done_cyc);
            check($sformatf("vec%0d err count", i), err_c.size(), 0);
            check($sformatf("vec%0d busy at accept", i), busy1, 1);
            check($sformatf("vec%0d sta issue", i), sta1, 1);
            check($sformatf("vec%0d sta finish", i), sta_done, 3);
            check($sformatf("vec%0d busy end", i), busy_end, 0);
            check($sformatf("vec%0d sta end", i), sta_end, 0);
            check($sformatf("vec%0d data stable", i), stab_bad, 0);
        end

        for (int i = 0; i < 12; i++) begin
            rd = $urandom;
            ri = $urandom;
            run(1'b0, rd, $urandom_range(55, 1), ri, -1, DONE_A + 15);
            cmp_bytes($sformatf("rand%0d", i), model_frame(rd, 4));
            check($sformatf("rand%0d done cycle", i), at(done_c, 0), DONE_A);
            check($sformatf("rand%0d done count", i), done_c.size(), 1);
            check($sformatf("rand%0d err count", i), err_c.size(), 0);
        end

        // Third byte of the next frame never gets its done.
        drop_at[0] = pulse_total[0] + 2;
        run(1'b0, 32'h12345678, -1, 32'h0, -1, 70);
        drop_at[0] = -1;
        e = model_frame(32'h12345678, 4);
        e = e[0:2];
        cmp_bytes("timeout", e);
        check("timeout err count", err_c.size(), 1);
        check("timeout err delay", at(err_c, 0) - at(got_c, 2), TO_A);
        check("timeout done count", done_c.size(), 0);
        check("timeout sta abort", sta_err, 4);
        check("timeout busy end", busy_end, 0);
        check("timeout sta end", sta_end, 0);

        // Reset while the fourth byte (index 3, pulse at cycle 38) waits for done.
        run(1'b0, 32'h12345678, -1, 32'h0, 42, 60);
        check("midrst busy", snap_busy, 0);
        check("midrst uart_send", snap_us, 0);
        check("midrst send_done", snap_sdn, 0);
        check("midrst err", snap_err, 0);
        check("midrst uart_send_data", snap_usd, 8'h00);
        check("midrst sta", snap_sta, 0);
        check("midrst byte count", got_b.size(), 4);
        check("midrst done count", done_c.size(), 0);
        check("midrst err count", err_c.size(), 0);
        run(1'b0, 32'h12345678, -1, 32'h0, -1, DONE_A + 10);
        cmp_bytes("after rst", model_frame(32'h12345678, 4));
        check("after rst done count", done_c.size(), 1);

        // DATA_W=8: second send in the cycle after send_done.
        run(1'b1, 32'h3C, DONE_B + 1, 32'h3C, -1, 2 * DONE_B + 20);
        e  = model_frame(32'h3C, 1);
        e2 = model_frame(32'h3C, 1);
        foreach (e2[k]) e.push_back(e2[k]);
        cmp_bytes("b2b", e);
        check("b2b done count", done_c.size(), 2);
        check("b2b done1 cycle", at(done_c, 0), DONE_B);
        check("b2b done2 cycle", at(done_c, 1), 2 * DONE_B + 1);
        check("b2b second latency", at(got_c, NB_B) - (DONE_B + 1), 2);
        check("b2b err count", err_c.size(), 0);
        check("b2b busy end", busy_end, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
